// File: rtl/prng_gen.sv
// Galois LFSR random-word source with runtime seed/polynomial load, warm-up discard,
// multi-step advance with entropy injection, and automatic all-zero lock-up recovery.
module prng_gen #(
  parameter int              W      = 32,
  parameter logic [W-1:0]    POLY   = 32'h80200003,
  parameter logic [W-1:0]    SEED   = 32'hdeadbeef,
  parameter int              STEP   = 1,
  parameter int              WARMUP = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [W-1:0]    load_seed,
  input  logic [W-1:0]    load_poly,
  input  logic [STEP-1:0] ent,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    res,
  output logic            lockup,
  output logic [7:0]      lock_cnt
);

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam state_t     INIT_STATE = (WARMUP == 0) ? RUN : WARM;
  localparam logic [7:0] WARM_LAST  = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

  state_t         state_reg, state_next;
  logic [7:0]     cnt_reg, cnt_next;
  logic [W-1:0]   res_reg;
  logic [W-1:0]   poly_reg;
  logic           lockup_reg;
  logic [7:0]     lock_cnt_reg;
  logic           advance;

  // chain[j] is the state before sub-step j; chain[STEP] is the full advance result
  logic [W-1:0]   chain [0:STEP];

  assign chain[0] = res_reg;

  generate
    for (genvar gi = 0; gi < STEP; gi++) begin : g_step
      assign chain[gi+1] = {ent[gi], chain[gi][W-1:1]} ^ (chain[gi][0] ? poly_reg : '0);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    advance    = 1'b0;
    if (load) begin
      state_next = INIT_STATE;
      cnt_next   = 8'd0;
    end else begin
      case (state_reg)
        WARM: begin
          advance  = 1'b1;
          cnt_next = cnt_reg + 8'd1;
          if (cnt_reg == WARM_LAST) begin
            state_next = RUN;
          end
        end
        RUN: begin
          advance = out_ready;
        end
        default: begin
          state_next = INIT_STATE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= INIT_STATE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_reg      <= SEED;
      poly_reg     <= POLY;
      lockup_reg   <= 1'b0;
      lock_cnt_reg <= 8'd0;
    end else if (load) begin
      res_reg    <= (load_seed != '0) ? load_seed : SEED;
      poly_reg   <= (load_poly != '0) ? load_poly : poly_reg;
      lockup_reg <= 1'b0;
    end else if (advance) begin
      if (chain[STEP] == '0) begin
        res_reg    <= SEED;
        lockup_reg <= 1'b1;
        if (lock_cnt_reg != 8'hff) begin
          lock_cnt_reg <= lock_cnt_reg + 8'd1;
        end
      end else begin
        res_reg    <= chain[STEP];
        lockup_reg <= 1'b0;
      end
    end else begin
      lockup_reg <= 1'b0;
    end
  end

  assign out_valid = (state_reg == RUN);
  assign res       = res_reg;
  assign lockup    = lockup_reg;
  assign lock_cnt  = lock_cnt_reg;

endmodule

// File: tb/tb_prng_gen.sv
// Directed bench for prng_gen: three instances (default, STEP=2, WARMUP=3) share
// clock, reset and control; expected words are hand-computed LFSR values.
module tb_prng_gen;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [31:0] load_seed;
  logic [31:0] load_poly;
  logic [0:0]  ent1;
  logic [1:0]  ent2;
  logic        out_ready;

  logic        d_valid, s_valid, w_valid;
  logic [31:0] d_res, s_res, w_res;
  logic        d_lock, s_lock, w_lock;
  logic [7:0]  d_cnt, s_cnt, w_cnt;

  int errors = 0;
  int checks = 0;

  prng_gen u_dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_seed(load_seed), .load_poly(load_poly),
    .ent(ent1), .out_valid(d_valid), .out_ready(out_ready), .res(d_res),
    .lockup(d_lock), .lock_cnt(d_cnt)
  );

  prng_gen #(.STEP(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_seed(load_seed), .load_poly(load_poly),
    .ent(ent2), .out_valid(s_valid), .out_ready(out_ready), .res(s_res),
    .lockup(s_lock), .lock_cnt(s_cnt)
  );

  prng_gen #(.WARMUP(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_seed(load_seed), .load_poly(load_poly),
    .ent(ent1), .out_valid(w_valid), .out_ready(out_ready), .res(w_res),
    .lockup(w_lock), .lock_cnt(w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    load      = 1'b0;
    load_seed = 32'h0;
    load_poly = 32'h0;
    ent1      = 1'b0;
    ent2      = 2'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load = 1'b0; load_seed = 32'h0; load_poly = 32'h0;
    ent1 = 1'b0; ent2 = 2'b0; out_ready = 1'b0;
    #12;
    checks++;
    if (d_res !== 32'hdeadbeef) begin errors++; $display("FAIL reset_res got=%h exp=deadbeef", d_res); end
    checks++;
    if (d_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got=%b exp=1", d_valid); end
    checks++;
    if (d_lock !== 1'b0 || d_cnt !== 8'd0) begin errors++; $display("FAIL reset_lock got=%b/%0d exp=0/0", d_lock, d_cnt); end
    checks++;
    if (w_valid !== 1'b0) begin errors++; $display("FAIL reset_warm_valid got=%b exp=0", w_valid); end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_step();
    do_reset();
    out_ready = 1'b1;
    tick();
    checks++;
    if (d_res !== 32'hef76df74) begin errors++; $display("FAIL step1_a got=%h exp=ef76df74", d_res); end
    checks++;
    if (s_res !== 32'h77bb6fba) begin errors++; $display("FAIL step2_a got=%h exp=77bb6fba", s_res); end
    tick();
    checks++;
    if (d_res !== 32'h77bb6fba) begin errors++; $display("FAIL step1_b got=%h exp=77bb6fba", d_res); end
    checks++;
    if (s_res !== 32'h9dcedbed) begin errors++; $display("FAIL step2_b got=%h exp=9dcedbed", s_res); end
    tick();
    checks++;
    if (d_res !== 32'h3bddb7dd) begin errors++; $display("FAIL step1_c got=%h exp=3bddb7dd", d_res); end
    $display("test_step done");
  endtask

  task automatic test_entropy();
    do_reset();
    out_ready = 1'b1;
    ent1 = 1'b1;
    ent2 = 2'b10;
    tick();
    checks++;
    if (d_res !== 32'h6f76df74) begin errors++; $display("FAIL ent_step1 got=%h exp=6f76df74", d_res); end
    // ent[0]=0 gives ef76df74, then ent[1]=1 gives f7bb6fba
    checks++;
    if (s_res !== 32'hf7bb6fba) begin errors++; $display("FAIL ent_step2 got=%h exp=f7bb6fba", s_res); end
    ent1 = 1'b0;
    ent2 = 2'b0;
    $display("test_entropy done");
  endtask

  task automatic test_hold();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (d_res !== 32'hdeadbeef || d_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_%0d got=%h/%b exp=deadbeef/1", i, d_res, d_valid);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (d_res !== 32'hef76df74) begin errors++; $display("FAIL hold_release got=%h exp=ef76df74", d_res); end
    $display("test_hold done");
  endtask

  task automatic test_warmup();
    logic [31:0] exp_res [0:2];
    exp_res[0] = 32'hef76df74;
    exp_res[1] = 32'h77bb6fba;
    exp_res[2] = 32'h3bddb7dd;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (w_valid !== 1'b0) begin errors++; $display("FAIL warm_valid_%0d got=%b exp=0", i, w_valid); end
      tick();
      checks++;
      if (w_res !== exp_res[i]) begin errors++; $display("FAIL warm_res_%0d got=%h exp=%h", i, w_res, exp_res[i]); end
    end
    checks++;
    if (w_valid !== 1'b1) begin errors++; $display("FAIL warm_done got=%b exp=1", w_valid); end
    tick();
    checks++;
    if (w_res !== 32'h3bddb7dd) begin errors++; $display("FAIL warm_hold got=%h exp=3bddb7dd", w_res); end
    out_ready = 1'b1;
    tick();
    checks++;
    if (w_res !== 32'h9dcedbed) begin errors++; $display("FAIL warm_accept got=%h exp=9dcedbed", w_res); end
    // load mid-warmup restarts the discard count
    do_reset();
    out_ready = 1'b0;
    tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (w_res !== 32'hdeadbeef || w_valid !== 1'b0) begin
      errors++; $display("FAIL warm_load got=%h/%b exp=deadbeef/0", w_res, w_valid);
    end
    tick();
    tick();
    checks++;
    if (w_valid !== 1'b0) begin errors++; $display("FAIL warm_restart got=%b exp=0", w_valid); end
    tick();
    checks++;
    if (w_valid !== 1'b1 || w_res !== 32'h3bddb7dd) begin
      errors++; $display("FAIL warm_relaunch got=%h/%b exp=3bddb7dd/1", w_res, w_valid);
    end
    $display("test_warmup done");
  endtask

  task automatic test_lockup();
    do_reset();
    out_ready = 1'b0;
    load = 1'b1;
    load_seed = 32'h00000003;
    load_poly = 32'h00000001;
    tick();
    load = 1'b0;
    load_seed = 32'h0;
    load_poly = 32'h0;
    checks++;
    if (d_res !== 32'h00000003 || d_lock !== 1'b0) begin
      errors++; $display("FAIL lock_load got=%h/%b exp=00000003/0", d_res, d_lock);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (d_res !== 32'hdeadbeef) begin errors++; $display("FAIL lock_res got=%h exp=deadbeef", d_res); end
    checks++;
    if (d_lock !== 1'b1 || d_cnt !== 8'd1) begin errors++; $display("FAIL lock_pulse got=%b/%0d exp=1/1", d_lock, d_cnt); end
    tick();
    checks++;
    if (d_lock !== 1'b0 || d_cnt !== 8'd1) begin errors++; $display("FAIL lock_clear got=%b/%0d exp=0/1", d_lock, d_cnt); end
    out_ready = 1'b1;
    tick();
    checks++;
    if (d_res !== 32'h6f56df76 || d_lock !== 1'b0) begin
      errors++; $display("FAIL lock_newpoly got=%h/%b exp=6f56df76/0", d_res, d_lock);
    end
    $display("test_lockup done");
  endtask

  task automatic test_load_handshake();
    do_reset();
    out_ready = 1'b1;
    load = 1'b1;
    load_seed = 32'h12345678;
    tick();
    load = 1'b0;
    load_seed = 32'h0;
    checks++;
    if (d_res !== 32'h12345678) begin errors++; $display("FAIL load_hs got=%h exp=12345678", d_res); end
    tick();
    checks++;
    if (d_res !== 32'h091a2b3c) begin errors++; $display("FAIL load_next got=%h exp=091a2b3c", d_res); end
    $display("test_load_handshake done");
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (w_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got=%b exp=1", w_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (d_res !== 32'hdeadbeef || d_lock !== 1'b0) begin
      errors++; $display("FAIL arst_res got=%h/%b exp=deadbeef/0", d_res, d_lock);
    end
    checks++;
    if (w_valid !== 1'b0 || w_res !== 32'hdeadbeef) begin
      errors++; $display("FAIL arst_warm got=%h/%b exp=deadbeef/0", w_res, w_valid);
    end
    rst_n = 1'b1;
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_step();
    test_entropy();
    test_hold();
    test_warmup();
    test_lockup();
    test_load_handshake();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
